// File: rtl/life_engine.sv
// Game of Life engine (B3/S23) on a ROWS x COLS grid: run/step control, LFSR fill, auto-halt on stable/extinct.
// Define LIFE_TORUS_EN for a toroidal board; by default cells beyond the edge count as dead.

module life_cell (
  input  logic       i_alive,
  input  logic [7:0] i_nb,
  output logic       o_next
);
  logic [3:0] w_cnt;

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < 8; i++) w_cnt = w_cnt + 4'(i_nb[i]);
  end

  assign o_next = (w_cnt == 4'd3) | (i_alive & (w_cnt == 4'd2));
endmodule

module life_engine #(
  parameter int          ROWS      = 8,
  parameter int          COLS      = 8,
  parameter int          PERIOD    = 1,
  parameter logic [63:0] LFSR_INIT = 64'hACE1_0000_0000_0001
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic [ROWS*COLS-1:0] seed,
  input  logic                 randomize,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 step,
  output logic [ROWS*COLS-1:0] grid,
  output logic [15:0]          gen_count,
  output logic                 running,
  output logic                 busy,
  output logic                 stable,
  output logic                 extinct
);
  localparam int N        = ROWS * COLS;
  localparam int FILL_CYC = (N + 63) / 64;
  localparam int FW       = $clog2(FILL_CYC) + 1;
  localparam int PW       = $clog2(PERIOD) + 1;
  localparam logic [FW-1:0] FILL_LAST = FW'(FILL_CYC - 1);
  localparam logic [PW-1:0] PRE_LAST  = PW'(PERIOD - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FILL} state_t;

  state_t         r_state, w_state_nxt;
  logic           r_armed;
  logic [63:0]    r_lfsr;
  logic [N-1:0]   r_grid, w_next, w_fill_val;
  logic [15:0]    r_gen;
  logic           r_stable, r_extinct;
  logic [FW-1:0]  r_fill_cnt;
  logic [PW-1:0]  r_pre;
  logic           w_load, w_gen, w_fill, w_fill_done, w_pre_clr, w_pre_inc, w_halt, w_fb;

  // Per-cell neighbour gather; K walks the 3x3 window, skipping the centre.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [7:0] w_nb;
      for (genvar k = 0; k < 9; k++) begin : g_nb
        if (k != 4) begin : g_use
          localparam int RR = r + k / 3 - 1;
          localparam int CC = c + k % 3 - 1;
          localparam int NI = (k < 4) ? k : k - 1;
`ifdef LIFE_TORUS_EN
          localparam int RW = (RR + ROWS) % ROWS;
          localparam int CW = (CC + COLS) % COLS;
          assign w_nb[NI] = r_grid[RW*COLS + CW];
`else
          if (RR < 0 || RR >= ROWS || CC < 0 || CC >= COLS) begin : g_edge
            assign w_nb[NI] = 1'b0;
          end else begin : g_in
            assign w_nb[NI] = r_grid[RR*COLS + CC];
          end
`endif
        end
      end
      life_cell u_cell (
        .i_alive (r_grid[r*COLS + c]),
        .i_nb    (w_nb),
        .o_next  (w_next[r*COLS + c])
      );
    end
  end

  // Fill shifts 64 LFSR bits in from the top; small grids take the low LFSR bits.
  if (N > 64) begin : g_fill_wide
    assign w_fill_val = {r_lfsr, r_grid[N-1:64]};
  end else if (N == 64) begin : g_fill_eq
    assign w_fill_val = r_lfsr;
  end else begin : g_fill_narrow
    assign w_fill_val = r_lfsr[N-1:0];
  end

  assign w_fb   = r_lfsr[63] ^ r_lfsr[62] ^ r_lfsr[60] ^ r_lfsr[59];
  assign w_halt = (w_next == r_grid) || (w_next == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_armed <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_gen       = 1'b0;
    w_fill      = 1'b0;
    w_fill_done = 1'b0;
    w_pre_clr   = 1'b0;
    w_pre_inc   = 1'b0;
    case (r_state)
      S_IDLE: if (r_armed) begin
        if (load)           w_load = 1'b1;
        else if (randomize) w_state_nxt = S_FILL;
        else if (stop)      w_state_nxt = S_IDLE;
        else if (start) begin
          w_state_nxt = S_RUN;
          w_pre_clr   = 1'b1;
        end else if (step)  w_gen = 1'b1;
      end
      S_RUN: begin
        if (load) begin
          w_load      = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (randomize) w_state_nxt = S_FILL;
        else if (stop)          w_state_nxt = S_IDLE;
        else if (r_pre == PRE_LAST) begin
          w_gen     = 1'b1;
          w_pre_clr = 1'b1;
          if (w_halt) w_state_nxt = S_IDLE;
        end else w_pre_inc = 1'b1;
      end
      S_FILL: begin
        w_fill = 1'b1;
        if (r_fill_cnt == FILL_LAST) begin
          w_fill_done = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsr     <= LFSR_INIT;
      r_grid     <= '0;
      r_gen      <= '0;
      r_stable   <= 1'b0;
      r_extinct  <= 1'b1;
      r_fill_cnt <= '0;
      r_pre      <= '0;
    end else begin
      r_lfsr <= {r_lfsr[62:0], w_fb};
      if (w_load) begin
        r_grid    <= seed;
        r_gen     <= '0;
        r_stable  <= 1'b0;
        r_extinct <= (seed == '0);
      end else if (w_gen) begin
        r_grid    <= w_next;
        r_stable  <= (w_next == r_grid);
        r_extinct <= (w_next == '0);
        if (r_gen != 16'hFFFF) r_gen <= r_gen + 16'd1;
      end else if (w_fill) begin
        r_grid <= w_fill_val;
        if (w_fill_done) begin
          r_gen     <= '0;
          r_stable  <= 1'b0;
          r_extinct <= (w_fill_val == '0);
        end
      end
      if (w_fill) r_fill_cnt <= w_fill_done ? '0 : r_fill_cnt + FW'(1);
      if (w_pre_clr)      r_pre <= '0;
      else if (w_pre_inc) r_pre <= r_pre + PW'(1);
    end
  end

  assign grid      = r_grid;
  assign gen_count = r_gen;
  assign running   = (r_state == S_RUN);
  assign busy      = (r_state == S_FILL);
  assign stable    = r_stable;
  assign extinct   = r_extinct;
endmodule
